// File: rtl/ap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ap_ctrl_pkg
// Description : Shared types and default widths for the ap_ctrl initiator
//               (state encoding, counter/latency/FIFO defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package ap_ctrl_pkg;

    // Default widths of the batch counters, cycle counter and FIFO depth
    localparam int c_CNT_W_DEF = 16;
    localparam int c_LAT_W_DEF = 32;
    localparam int c_DEPTH_DEF = 4;

    // Batch controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ap_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ap_ts_fifo
// Description : Small synchronous FIFO holding start timestamps of outstanding
//               transactions. Supports push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ts_fifo
    import ap_ctrl_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int WIDTH = c_LAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_PTR_W:0]   r_count_q;
    logic [c_PTR_W:0]   w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    // Pointer/occupancy update; a push into a full FIFO is only allowed when a pop frees a slot
    always_comb begin
        w_do_pop   = i_pop & (r_count_q != '0);
        w_do_push  = i_push & ((r_count_q != c_FULL_CNT) | w_do_pop);
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_mem_d    = r_mem_q;
        if (w_do_push) begin
            w_mem_d[r_wr_ptr_q] = i_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointers and occupancy empty out on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign o_data  = r_mem_q[r_rd_ptr_q];
    assign o_full  = (r_count_q == c_FULL_CNT);
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_driver.sv
`default_nettype none
// ============================================================================
// Module      : ap_ctrl_driver
// Description : Initiator for the HLS ap_start/ap_ready/ap_done/ap_continue
//               handshake. Launches a batch of transactions, tracks the
//               outstanding ones with a timestamp FIFO, reports per-transaction
//               latency and flags the end of the batch.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ctrl_driver
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF,
    parameter int LAT_W = c_LAT_W_DEF,
    parameter int DEPTH = c_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             sink_ready,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             lat_valid,
    output logic [LAT_W-1:0] last_latency,
    output logic             protocol_err
);

    localparam int                 c_OCC_W    = $clog2(DEPTH) + 1;
    localparam logic [c_OCC_W-1:0] c_FULL_OCC = c_OCC_W'(DEPTH);

    state_e             r_state_q;
    state_e             w_state_d;
    logic [CNT_W-1:0]   r_target_q;
    logic [CNT_W-1:0]   w_target_d;
    logic [CNT_W-1:0]   r_started_q;
    logic [CNT_W-1:0]   w_started_d;
    logic [CNT_W-1:0]   r_done_q;
    logic [CNT_W-1:0]   w_done_d;
    logic               r_start_q;
    logic               w_start_d;
    logic               r_perr_q;
    logic               w_perr_d;
    logic               r_lat_valid_q;
    logic               w_lat_valid_d;
    logic [LAT_W-1:0]   r_last_lat_q;
    logic [LAT_W-1:0]   w_last_lat_d;
    logic [LAT_W-1:0]   r_cycle_q;
    logic [LAT_W-1:0]   w_cycle_d;

    logic               w_busy;
    logic               w_run_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_complete;
    logic               w_continue;
    logic [c_OCC_W-1:0] w_occ_d;
    logic               w_full_next;
    logic [LAT_W-1:0]   w_fifo_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_OCC_W-1:0] w_fifo_count;

    // Handshake qualifiers derived from the current state and DUT inputs
    always_comb begin
        w_busy       = (r_state_q == S_RUN) | (r_state_q == S_DRAIN);
        w_run_accept = run & ((r_state_q == S_IDLE) | (r_state_q == S_DONE));
        w_continue   = sink_ready & w_busy;
        w_push       = r_start_q & ap_ready;
        w_complete   = ap_done & w_continue;
        w_pop        = w_complete & ~w_fifo_empty;
    end

    ap_ts_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LAT_W)
    ) u_ts_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (r_cycle_q),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Next state, counters, latency and the registered ap_start request
    always_comb begin
        w_state_d     = r_state_q;
        w_target_d    = r_target_q;
        w_started_d   = r_started_q;
        w_done_d      = r_done_q;
        w_perr_d      = r_perr_q;
        w_lat_valid_d = w_pop;
        w_last_lat_d  = r_last_lat_q;
        w_cycle_d     = r_cycle_q + 1'b1;

        if (w_push) begin
            w_started_d = r_started_q + 1'b1;
        end
        if (w_pop) begin
            w_done_d     = r_done_q + 1'b1;
            w_last_lat_d = r_cycle_q - w_fifo_head;
        end
        if (w_complete & w_fifo_empty) begin
            w_perr_d = 1'b1;
        end

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (w_run_accept) begin
                    w_target_d  = num_txn;
                    w_started_d = '0;
                    w_done_d    = '0;
                    w_perr_d    = 1'b0;
                    w_state_d   = (num_txn == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_started_d == r_target_q) begin
                    w_state_d = (w_done_d == r_target_q) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done_d == r_target_q) begin
                    w_state_d = S_DONE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // Occupancy after this edge decides whether another start may be issued
        case ({w_push, w_pop})
            2'b10:   w_occ_d = w_fifo_count + 1'b1;
            2'b01:   w_occ_d = w_fifo_count - 1'b1;
            default: w_occ_d = w_fifo_count;
        endcase
        w_full_next = (w_occ_d == c_FULL_OCC);

        // A pending start is held until the DUT takes it
        w_start_d = (w_state_d == S_RUN) & (w_started_d < w_target_d) & ~w_full_next;
        if (r_start_q & ~ap_ready) begin
            w_start_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Datapath registers: counters, start request, latency, error flag, cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_target_q    <= '0;
            r_started_q   <= '0;
            r_done_q      <= '0;
            r_start_q     <= 1'b0;
            r_perr_q      <= 1'b0;
            r_lat_valid_q <= 1'b0;
            r_last_lat_q  <= '0;
            r_cycle_q     <= '0;
        end else begin
            r_target_q    <= w_target_d;
            r_started_q   <= w_started_d;
            r_done_q      <= w_done_d;
            r_start_q     <= w_start_d;
            r_perr_q      <= w_perr_d;
            r_lat_valid_q <= w_lat_valid_d;
            r_last_lat_q  <= w_last_lat_d;
            r_cycle_q     <= w_cycle_d;
        end
    end

    assign ap_start     = r_start_q;
    assign ap_continue  = w_continue;
    assign busy         = w_busy;
    assign finish       = (r_state_q == S_DONE);
    assign started_cnt  = r_started_q;
    assign done_cnt     = r_done_q;
    assign lat_valid    = r_lat_valid_q;
    assign last_latency = r_last_lat_q;
    assign protocol_err = r_perr_q;

endmodule
`default_nettype wire
